mul_seq: RTL and testbench

- Multi-cycle 32x32->64 multiply sequencer.
- Has no adder of its own. It borrows the shared combinational ALU and runs shift-add: one ADDU per cycle for 32 iterations.
- Sits beside the execute stage. While it runs, it asserts alu_sel, and the execute-stage operand/opcode mux hands the ALU to this block.
- Signed multiply uses magnitude conditioning before the loop and sign correction after it.

---
 rtl/mul_seq_if.sv | 33 +++
 rtl/mul_seq.sv | 106 ++++++++++
 tb/tb_mul_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Bus between mul_seq and the execute stage: request/result handshake plus
// the borrowed-ALU operand/opcode/result path.
`ifndef OPCODE_ADDU
`define OPCODE_ADDU 6'h21
`endif

interface mul_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        alu_sel;
    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic [2:0]  alu_flags;

    modport master (
        output start, is_signed, op_a, op_b, flush, alu_out, alu_flags,
        input  busy, done, res_hi, res_lo, alu_sel, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, is_signed, op_a, op_b, flush, alu_out, alu_flags,
        output busy, done, res_hi, res_lo, alu_sel, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/mul_seq.sv
// Multi-cycle 32x32->64 shift-add multiplier that borrows the shared execute
// ALU for one ADDU per iteration; signed operands go through magnitude/sign fix.
module mul_seq #(
    parameter int unsigned ITER  = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic        clk,
    input logic        rst,
    mul_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        hi, lo, mcand;
    logic [31:0]        res_hi_q, res_lo_q;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic               accept;
    logic               last_iter;
    logic [31:0]        mag_a, mag_b;
    logic [63:0]        fixed;
    logic               unused_flags;

    always_comb begin
        accept    = (state == S_IDLE) && bus.start && !bus.flush;
        last_iter = (cnt == CNT_W'(ITER - 1));
        // 0x80000000 maps onto itself, which is the correct unsigned magnitude
        mag_a     = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
        mag_b     = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;
        fixed     = neg ? (~{hi, lo} + 64'd1) : {hi, lo};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            S_PREP: state_nxt = bus.flush ? S_IDLE : S_ITER;
            S_ITER: begin
                if (bus.flush)      state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = bus.flush ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        neg   <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                        mcand <= mag_a;
                        lo    <= mag_b;
                        hi    <= '0;
                        cnt   <= '0;
                    end
                end
                S_ITER: begin
                    // {carry, sum, lo} shifted right by one: the ALU sum feeds hi, its LSB enters lo
                    if (!bus.flush) begin
                        hi  <= {bus.alu_flags[0], bus.alu_out[31:1]};
                        lo  <= {bus.alu_out[0], lo[31:1]};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        {hi, lo}             <= fixed;
                        {res_hi_q, res_lo_q} <= fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign bus.done    = (state == S_DONE);
    assign bus.alu_sel = (state == S_ITER);
    assign bus.alu_op  = (state == S_ITER) ? `OPCODE_ADDU : 6'd0;
    assign bus.alu_a   = hi;
    assign bus.alu_b   = lo[0] ? mcand : '0;
    assign bus.res_hi  = res_hi_q;
    assign bus.res_lo  = res_lo_q;

    assign unused_flags = ^bus.alu_flags[2:1];
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a behavioural shared ALU and
// hand-computed products, latencies and flush/reset behaviour.
module tb_mul_seq;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    mul_seq_if bus ();

    mul_seq #(.ITER(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU: ADDU gives sum plus carry-out on flags[0]
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = 33'd0;
        if (bus.alu_op == `OPCODE_ADDU)
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    end
    assign bus.alu_out   = alu_sum[31:0];
    assign bus.alu_flags = {1'b0, (alu_sum[31:0] == 32'd0), alu_sum[32]};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an operation in cycle 0 and observe cycles 1..40. If poke > 0,
    // a second start (1*1) is pulsed in that cycle and must be ignored.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int poke);
        int done_cyc = -1;
        int n_done   = 0;
        int bad_busy = 0;
        int bad_sel  = 0;
        int bad_op   = 0;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.busy !== ((c >= 1) && (c <= 34))) bad_busy++;
            if (bus.alu_sel !== ((c >= 2) && (c <= 33))) bad_sel++;
            if (bus.alu_op !== (((c >= 2) && (c <= 33)) ? `OPCODE_ADDU : 6'd0)) bad_op++;
            if (c == poke) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b0;
                bus.op_a      = 32'd1;
                bus.op_b      = 32'd1;
            end
            tick();
            bus.start = 1'b0;
        end
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'd35);
        chk({tag, " done_count"}, 64'(n_done), 64'd1);
        chk({tag, " busy_profile"}, 64'(bad_busy), 64'd0);
        chk({tag, " alu_sel_profile"}, 64'(bad_sel), 64'd0);
        chk({tag, " alu_op_profile"}, 64'(bad_op), 64'd0);
        chk({tag, " res_hi"}, 64'(bus.res_hi), 64'(exp_hi));
        chk({tag, " res_lo"}, 64'(bus.res_lo), 64'(exp_lo));
    endtask

    initial begin
        int n_done;
        tests         = 0;
        failed        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        tick();
        tick();
        chk("reset busy",    64'(bus.busy),    64'd0);
        chk("reset done",    64'(bus.done),    64'd0);
        chk("reset alu_sel", 64'(bus.alu_sel), 64'd0);
        chk("reset alu_op",  64'(bus.alu_op),  64'd0);
        chk("reset res_hi",  64'(bus.res_hi),  64'd0);
        chk("reset res_lo",  64'(bus.res_lo),  64'd0);
        rst = 1'b0;
        tick();

        run_op("u3x5",    1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F, 0);
        run_op("uFFxFF",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 0);
        run_op("sm2x3",   1'b1, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        run_op("smin2",   1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 0);
        run_op("s5xm7",   1'b1, 32'd5,          32'hFFFFFFF9,   32'hFFFFFFFF, 32'hFFFFFFDD, 0);
        run_op("sm1xm1",  1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001, 0);
        run_op("uFFx2",   1'b0, 32'hFFFFFFFF,   32'd2,          32'h00000001, 32'hFFFFFFFE, 0);
        run_op("u7x9re",  1'b0, 32'd7,          32'd9,          32'h00000000, 32'h0000003F, 10);

        // flush in ITER: idle next cycle, no done, result untouched
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'd2;
        bus.op_b      = 32'd2;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy",    64'(bus.busy),    64'd0);
        chk("flush alu_sel", 64'(bus.alu_sel), 64'd0);
        chk("flush alu_op",  64'(bus.alu_op),  64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        chk("flush no_done", 64'(n_done),     64'd0);
        chk("flush res_lo",  64'(bus.res_lo), 64'h3F);
        chk("flush res_hi",  64'(bus.res_hi), 64'h0);

        // start together with flush in IDLE is not accepted
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("startflush busy", 64'(bus.busy), 64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
            tick();
        end
        chk("startflush no_activity", 64'(n_done),     64'd0);
        chk("startflush res_lo",      64'(bus.res_lo), 64'h3F);

        // rst in cycle 20 of an operation
        bus.start = 1'b1;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst busy",    64'(bus.busy),    64'd0);
        chk("rst alu_sel", 64'(bus.alu_sel), 64'd0);
        chk("rst done",    64'(bus.done),    64'd0);
        chk("rst res_hi",  64'(bus.res_hi),  64'd0);
        chk("rst res_lo",  64'(bus.res_lo),  64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        chk("rst no_done", 64'(n_done), 64'd0);

        run_op("u4x4", 1'b0, 32'd4, 32'd4, 32'h00000000, 32'h00000010, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
